hermes_cfg_regs: RTL and testbench
==================================

// Module: hermes_cfg_regs
// PURPOSE
//  Register-mapped source of the Hermes endpoint configuration (hermes_cfg_t) consumed by the Hermes datapath.
//  Software writes shadow registers over a simple 32-bit register port, then commits them.
//  Commit runs a drain handshake with the datapath: drop vld, wait for idle, load, hold off, re-assert vld.
// PARAMETERS
//  HOLDOFF_CYCLES  16    cycles vld stays low after active load before re-assert (>=1)
//  DRAIN_TIMEOUT   4096  max cycles waiting for dp_idle before forced load (>=2)
// PORTS
//  clk         in   1   sole clock
//  rst_n       in   1   async active-low reset
//  reg_wr      in   1   write strobe, single cycle
//  reg_rd      in   1   read strobe, single cycle
//  reg_addr    in   4   word address
//  reg_wdata   in   32  write data
//  reg_rdata   out  32  read data, valid when reg_rvld
//  reg_rvld    out  1   read response strobe
//  dp_idle     in   1   datapath has no frame in flight using cfg
//  cfg         out  hermes_cfg_t  active configuration {vld,fpga_mac,fpga_ip,host_mac,host_ip}
//  commit_err  out  1   sticky: drain timeout or rejected commit; W1C via CTRL[4]
// BEHAVIOUR
//  Reset: all shadow/active fields 0, cfg.vld=0, ENABLE=0, FSM=IDLE, reg_rvld=0, reg_rdata=0, commit_err=0, COMMIT_CNT=0.
//  Map: 0 CTRL, 1 FPGA_MAC[31:0], 2 FPGA_MAC[47:32] (bits 31:16 RAZ/WI), 3 FPGA_IP, 4 HOST_MAC[31:0], 5 HOST_MAC[47:32], 6 HOST_IP, 7 COMMIT_CNT (RO 16b); 8-15 read 0, writes ignored.
//  CTRL: [0] COMMIT W1S self-clear; [1] ENABLE RW; [2] BUSY RO (FSM!=IDLE or pending); [3] cfg.vld RO; [4] commit_err, write 1 clears.
//  Reads: reg_rvld/reg_rdata registered, 1-cycle latency; reads of 1-6 return SHADOW values. rd+wr same cycle, same addr: read returns old value.
//  Shadow writes take effect next cycle; never alter cfg fields directly.
//  FSM IDLE->DRAIN on commit request (or pending flag) if shadow valid; else commit_err=1, stays IDLE, count unchanged.
//  Shadow valid: fpga_mac[40]==0 (unicast) and fpga_ip!=0.
//  DRAIN: cfg.vld=0 from first DRAIN cycle. dp_idle=1 -> LOAD. Timeout after DRAIN_TIMEOUT cycles -> LOAD and commit_err=1.
//  LOAD (1 cycle): shadow -> active fields; COMMIT_CNT+1, wraps 0xFFFF->0.
//  HOLD: HOLDOFF_CYCLES cycles, vld=0 -> IDLE.
//  In IDLE: cfg.vld = ENABLE & loaded_once (loaded_once set at first LOAD, cleared only by reset).
//  Timing: cfg.vld rises the cycle after HOLD exits.
//  ENABLE 1->0: cfg.vld low next cycle in any state; FSM keeps running.
//  Commit while BUSY: latched into single pending flag (extra commits merge), serviced on return to IDLE with shadow values at that time.
//  Shadow writes during DRAIN/HOLD allowed: they apply to a pending commit only, not the in-progress load.
//  cfg fields change only in LOAD, always while cfg.vld=0.
//  Async reset mid-operation returns everything to reset values immediately; no commit survives.
// TESTING
//  1. Reset, write all shadows, ENABLE=1, COMMIT with dp_idle=1 -> LOAD 2 cycles after commit write; vld=1 after 16 HOLD cycles; COMMIT_CNT=1.
//  2. cfg active, dp_idle=0 for 100 cycles, recommit -> vld=0 from next cycle; fields unchanged until dp_idle=1; then load; commit_err=0.
//  3. dp_idle stuck 0 -> forced LOAD after 4096 DRAIN cycles; commit_err=1; W1C CTRL[4] clears it.
//  4. fpga_mac=01:00:5E:00:00:01 (bit40=1), COMMIT -> commit_err=1, cfg unchanged, COMMIT_CNT unchanged.
//  5. Three COMMIT writes during HOLD, shadow changed between -> exactly one extra load with final shadow values; COMMIT_CNT +2 total.
//  6. ENABLE=0 mid-HOLD, then rst_n pulse mid-DRAIN -> vld stays 0; after reset all reads are 0 and reg_rvld timing is 1 cycle.

Source files
------------

// File: rtl/hermes_cfg_regs.sv
// Hermes endpoint configuration registers.
// Software fills shadow registers, then commits. A commit drains the datapath,
// loads shadow into the active config, holds off, and re-asserts cfg.vld.

package hermes_cfg_pkg;
    typedef struct packed {
        logic        vld;
        logic [47:0] fpga_mac;
        logic [31:0] fpga_ip;
        logic [47:0] host_mac;
        logic [31:0] host_ip;
    } hermes_cfg_t;
endpackage

module hermes_cfg_regs
    import hermes_cfg_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int DRAIN_TIMEOUT  = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_reg_wr,
    input  logic        i_reg_rd,
    input  logic [3:0]  i_reg_addr,
    input  logic [31:0] i_reg_wdata,
    output logic [31:0] o_reg_rdata,
    output logic        o_reg_rvld,
    input  logic        i_dp_idle,
    output hermes_cfg_t o_cfg,
    output logic        o_commit_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // One counter serves both the drain timeout and the holdoff window.
    localparam int CNT_MAX = (DRAIN_TIMEOUT > HOLDOFF_CYCLES) ? DRAIN_TIMEOUT : HOLDOFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLDOFF_CYCLES - 1);

    // Shadow (software-visible) fields
    logic [47:0] r_sh_fpga_mac;
    logic [31:0] r_sh_fpga_ip;
    logic [47:0] r_sh_host_mac;
    logic [31:0] r_sh_host_ip;

    // Active fields driven to the datapath
    logic [47:0] r_act_fpga_mac;
    logic [31:0] r_act_fpga_ip;
    logic [47:0] r_act_host_mac;
    logic [31:0] r_act_host_ip;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pend;
    logic          r_enable;
    logic          r_loaded_once;
    logic          r_err;
    logic [15:0]   r_commit_cnt;

    logic          w_wr_ctrl;
    logic          w_commit;
    logic          w_err_clr;
    logic          w_shadow_ok;
    logic          w_vld;
    logic          w_busy;
    logic [31:0]   w_rd_mux;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pend_nxt;
    logic          w_err_set;
    logic          w_do_load;

    assign w_wr_ctrl   = i_reg_wr && (i_reg_addr == 4'd0);
    assign w_commit    = w_wr_ctrl && i_reg_wdata[0];
    assign w_err_clr   = w_wr_ctrl && i_reg_wdata[4];
    // Multicast source MAC or a zero IP is never a usable endpoint config.
    assign w_shadow_ok = !r_sh_fpga_mac[40] && (r_sh_fpga_ip != 32'd0);
    assign w_busy      = (r_state != S_IDLE) || r_pend;
    // Pending commit in IDLE is about to drain, so keep vld low for that cycle.
    assign w_vld       = (r_state == S_IDLE) && !r_pend && r_enable && r_loaded_once;

    assign o_cfg.vld      = w_vld;
    assign o_cfg.fpga_mac = r_act_fpga_mac;
    assign o_cfg.fpga_ip  = r_act_fpga_ip;
    assign o_cfg.host_mac = r_act_host_mac;
    assign o_cfg.host_ip  = r_act_host_ip;
    assign o_commit_err   = r_err;

    // Commit FSM next-state: drain, load, holdoff; commits while busy merge into r_pend.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_err_set   = 1'b0;
        w_do_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pend_nxt = 1'b0;
                if (w_commit || r_pend) begin
                    if (w_shadow_ok) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_pend_nxt = r_pend || w_commit;
                if (i_dp_idle) begin
                    w_state_nxt = S_LOAD;
                end else if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_LOAD;
                    w_err_set   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_LOAD: begin
                w_pend_nxt  = r_pend || w_commit;
                w_do_load   = 1'b1;
                w_state_nxt = S_HOLD;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_pend_nxt = r_pend || w_commit;
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // FSM state, counter, pending flag, sticky error, commit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pend        <= 1'b0;
            r_err         <= 1'b0;
            r_loaded_once <= 1'b0;
            r_commit_cnt  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_do_load) begin
                r_loaded_once <= 1'b1;
                r_commit_cnt  <= r_commit_cnt + 16'd1;
            end
        end
    end

    // Software register writes: ENABLE and shadow fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_enable      <= 1'b0;
            r_sh_fpga_mac <= '0;
            r_sh_fpga_ip  <= '0;
            r_sh_host_mac <= '0;
            r_sh_host_ip  <= '0;
        end else if (i_reg_wr) begin
            case (i_reg_addr)
                4'd0: r_enable               <= i_reg_wdata[1];
                4'd1: r_sh_fpga_mac[31:0]    <= i_reg_wdata;
                4'd2: r_sh_fpga_mac[47:32]   <= i_reg_wdata[15:0];
                4'd3: r_sh_fpga_ip           <= i_reg_wdata;
                4'd4: r_sh_host_mac[31:0]    <= i_reg_wdata;
                4'd5: r_sh_host_mac[47:32]   <= i_reg_wdata[15:0];
                4'd6: r_sh_host_ip           <= i_reg_wdata;
                default: ;
            endcase
        end
    end

    // Active fields move only in LOAD, which always has cfg.vld low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_fpga_mac <= '0;
            r_act_fpga_ip  <= '0;
            r_act_host_mac <= '0;
            r_act_host_ip  <= '0;
        end else if (w_do_load) begin
            r_act_fpga_mac <= r_sh_fpga_mac;
            r_act_fpga_ip  <= r_sh_fpga_ip;
            r_act_host_mac <= r_sh_host_mac;
            r_act_host_ip  <= r_sh_host_ip;
        end
    end

    // Read mux; uses pre-write register values so same-cycle rd/wr returns old data.
    always_comb begin
        w_rd_mux = 32'd0;
        case (i_reg_addr)
            4'd0: w_rd_mux = {27'd0, r_err, w_vld, w_busy, r_enable, 1'b0};
            4'd1: w_rd_mux = r_sh_fpga_mac[31:0];
            4'd2: w_rd_mux = {16'd0, r_sh_fpga_mac[47:32]};
            4'd3: w_rd_mux = r_sh_fpga_ip;
            4'd4: w_rd_mux = r_sh_host_mac[31:0];
            4'd5: w_rd_mux = {16'd0, r_sh_host_mac[47:32]};
            4'd6: w_rd_mux = r_sh_host_ip;
            4'd7: w_rd_mux = {16'd0, r_commit_cnt};
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Registered read response, one cycle after the strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_rvld  <= 1'b0;
            o_reg_rdata <= 32'd0;
        end else begin
            o_reg_rvld <= i_reg_rd;
            if (i_reg_rd) begin
                o_reg_rdata <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_hermes_cfg_regs.sv
// Bench for hermes_cfg_regs: register reads are checked by a scoreboard
// monitor; cfg port and sticky error are checked directly at known cycles.
module tb_hermes_cfg_regs;
    import hermes_cfg_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvld;
    logic        dp_idle;
    hermes_cfg_t cfg;
    logic        commit_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    hermes_cfg_regs #(.HOLDOFF_CYCLES(16), .DRAIN_TIMEOUT(4096)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_reg_wr(reg_wr), .i_reg_rd(reg_rd),
        .i_reg_addr(reg_addr), .i_reg_wdata(reg_wdata), .o_reg_rdata(reg_rdata),
        .o_reg_rvld(reg_rvld), .i_dp_idle(dp_idle), .o_cfg(cfg), .o_commit_err(commit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every read response pops one expected value.
    always @(negedge clk) begin
        if (reg_rvld) begin
            if (exp_q.size() == 0) begin
                chk("rvld_unexpected", 64'd1, 64'd0);
            end else begin
                chk("rdata", {32'd0, reg_rdata}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        reg_rd = 1'b1; reg_addr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        reg_rd = 1'b0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp_old);
        @(negedge clk);
        reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        exp_q.push_back(exp_old);
        @(negedge clk);
        reg_rd = 1'b0; reg_wr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 4'd0;
        reg_wdata = 32'd0; dp_idle = 1'b1;
        wait_cycles(3);
        // Reset state
        chk("rst_vld", {63'd0, cfg.vld}, 64'd0);
        chk("rst_fpga_ip", {32'd0, cfg.fpga_ip}, 64'd0);
        chk("rst_host_mac", {16'd0, cfg.host_mac}, 64'd0);
        chk("rst_rvld", {63'd0, reg_rvld}, 64'd0);
        chk("rst_rdata", {32'd0, reg_rdata}, 64'd0);
        chk("rst_err", {63'd0, commit_err}, 64'd0);
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: program shadows and first commit
        wr(4'd1, 32'h2233_4455);
        wr(4'd2, 32'hABCD_0011);
        wr(4'd3, 32'hC0A8_0001);
        wr(4'd4, 32'h0C0D_0E0F);
        wr(4'd5, 32'h0000_0A0B);
        wr(4'd6, 32'hC0A8_0064);
        rd(4'd1, 32'h2233_4455);
        rd(4'd2, 32'h0000_0011);
        rd(4'd5, 32'h0000_0A0B);
        rdwr(4'd3, 32'hC0A8_0002, 32'hC0A8_0001);
        rd(4'd3, 32'hC0A8_0002);
        chk("t1_shadow_not_active", {32'd0, cfg.fpga_ip}, 64'd0);
        rd(4'd9, 32'd0);
        wr(4'd0, 32'h2);
        wr(4'd0, 32'h3);
        chk("t1_drain_vld", {63'd0, cfg.vld}, 64'd0);
        wait_cycles(1);
        chk("t1_load_cyc_ip", {32'd0, cfg.fpga_ip}, 64'd0);
        wait_cycles(1);
        chk("t1_loaded_ip", {32'd0, cfg.fpga_ip}, {32'd0, 32'hC0A8_0002});
        chk("t1_loaded_fmac", {16'd0, cfg.fpga_mac}, {16'd0, 48'h0011_2233_4455});
        chk("t1_loaded_hmac", {16'd0, cfg.host_mac}, {16'd0, 48'h0A0B_0C0D_0E0F});
        chk("t1_hold_vld", {63'd0, cfg.vld}, 64'd0);
        wait_cycles(15);
        chk("t1_hold_end_vld", {63'd0, cfg.vld}, 64'd0);
        wait_cycles(1);
        chk("t1_vld_up", {63'd0, cfg.vld}, 64'd1);
        rd(4'd0, 32'h0000_000A);
        rd(4'd7, 32'd1);

        // 2: recommit with datapath busy for 100 cycles
        wr(4'd6, 32'hC0A8_00C8);
        dp_idle = 1'b0;
        wr(4'd0, 32'h3);
        chk("t2_vld_drop", {63'd0, cfg.vld}, 64'd0);
        wait_cycles(100);
        chk("t2_field_held", {32'd0, cfg.host_ip}, {32'd0, 32'hC0A8_0064});
        chk("t2_vld_low", {63'd0, cfg.vld}, 64'd0);
        dp_idle = 1'b1;
        wait_cycles(2);
        chk("t2_field_new", {32'd0, cfg.host_ip}, {32'd0, 32'hC0A8_00C8});
        wait_cycles(20);
        chk("t2_vld_up", {63'd0, cfg.vld}, 64'd1);
        chk("t2_err", {63'd0, commit_err}, 64'd0);
        rd(4'd0, 32'h0000_000A);
        rd(4'd7, 32'd2);

        // 3: drain timeout forces the load
        wr(4'd6, 32'h0A00_0001);
        dp_idle = 1'b0;
        wr(4'd0, 32'h3);
        wait_cycles(4095);
        chk("t3_pre_timeout_err", {63'd0, commit_err}, 64'd0);
        chk("t3_pre_timeout_ip", {32'd0, cfg.host_ip}, {32'd0, 32'hC0A8_00C8});
        wait_cycles(1);
        chk("t3_timeout_err", {63'd0, commit_err}, 64'd1);
        wait_cycles(1);
        chk("t3_forced_load", {32'd0, cfg.host_ip}, {32'd0, 32'h0A00_0001});
        dp_idle = 1'b1;
        wait_cycles(20);
        rd(4'd0, 32'h0000_001A);
        wr(4'd0, 32'h12);
        chk("t3_w1c", {63'd0, commit_err}, 64'd0);
        rd(4'd7, 32'd3);

        // 4: multicast source MAC rejected
        wr(4'd2, 32'h0000_0100);
        wr(4'd1, 32'h5E00_0001);
        wr(4'd0, 32'h3);
        chk("t4_err", {63'd0, commit_err}, 64'd1);
        chk("t4_vld_kept", {63'd0, cfg.vld}, 64'd1);
        chk("t4_mac_kept", {16'd0, cfg.fpga_mac}, {16'd0, 48'h0011_2233_4455});
        rd(4'd7, 32'd3);
        wr(4'd0, 32'h12);
        wr(4'd2, 32'h0000_0011);
        wr(4'd1, 32'h2233_4455);

        // 5: commits during HOLD merge into one extra load
        wr(4'd6, 32'h0000_00A0);
        wr(4'd0, 32'h3);
        wait_cycles(3);
        chk("t5_first_load", {32'd0, cfg.host_ip}, {32'd0, 32'h0000_00A0});
        wr(4'd6, 32'h0000_00A1);
        wr(4'd0, 32'h3);
        wr(4'd6, 32'h0000_00A2);
        wr(4'd0, 32'h3);
        wr(4'd6, 32'h0000_00A3);
        wr(4'd0, 32'h3);
        rd(4'd0, 32'h0000_0006);
        wait_cycles(60);
        chk("t5_final_ip", {32'd0, cfg.host_ip}, {32'd0, 32'h0000_00A3});
        chk("t5_vld", {63'd0, cfg.vld}, 64'd1);
        rd(4'd7, 32'd5);

        // 6: ENABLE off mid-HOLD, then reset mid-DRAIN
        wr(4'd0, 32'h3);
        wait_cycles(3);
        wr(4'd0, 32'h0);
        wait_cycles(20);
        chk("t6_disabled_vld", {63'd0, cfg.vld}, 64'd0);
        rd(4'd0, 32'h0);
        rd(4'd7, 32'd6);
        dp_idle = 1'b0;
        wr(4'd0, 32'h3);
        wait_cycles(5);
        chk("t6_drain_vld", {63'd0, cfg.vld}, 64'd0);
        chk("t6_q_drained", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", {63'd0, cfg.vld}, 64'd0);
        chk("t6_rst_ip", {32'd0, cfg.host_ip}, 64'd0);
        chk("t6_rst_fmac", {16'd0, cfg.fpga_mac}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dp_idle = 1'b1;
        wait_cycles(5);
        chk("t6_no_commit_survives", {32'd0, cfg.host_ip}, 64'd0);
        // rvld latency: strobe at one negedge, response visible at the next
        @(negedge clk);
        reg_rd = 1'b1; reg_addr = 4'd0;
        exp_q.push_back(32'd0);
        @(negedge clk);
        reg_rd = 1'b0;
        chk("t6_rvld_1cyc", {63'd0, reg_rvld}, 64'd1);
        @(negedge clk);
        chk("t6_rvld_drop", {63'd0, reg_rvld}, 64'd0);
        for (int a = 1; a < 16; a++) rd(4'(a), 32'd0);

        wait_cycles(3);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
